codificador: RTL and testbench

// - 4-bit code converter for the coding-system datapath: captures a 4-bit word on inputs A..D (A = MSB)

---
 rtl/codificador_if.sv | 17 +
 rtl/codificador.sv | 122 ++++++++++++
 tb/tb_codificador.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/codificador_if.sv
// Signal bundle between the word producer and codificador: input word A..D, ready strobe,
// coded result S3..S0 and valid. The parity bit P exists only when CODIFICADOR_PARITY_EN is defined.
interface codificador_if;
  logic A, B, C, D;
  logic ready;
  logic S3, S2, S1, S0;
  logic valid;
`ifdef CODIFICADOR_PARITY_EN
  logic P;

  modport master (output A, B, C, D, ready, input S3, S2, S1, S0, valid, P);
  modport slave  (input A, B, C, D, ready, output S3, S2, S1, S0, valid, P);
`else
  modport master (output A, B, C, D, ready, input S3, S2, S1, S0, valid);
  modport slave  (input A, B, C, D, ready, output S3, S2, S1, S0, valid);
`endif
endinterface

// File: rtl/codificador.sv
// 4-bit code converter: latches A..D on a rising ready edge, emits Gray / Excess-3 / one's
// complement on S3..S0 after LATENCY clocks. Define CODIFICADOR_PARITY_EN to add parity output P.
module codificador #(
  parameter int CODE    = 0,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  codificador_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  if (!(CODE inside {[0:2]})) begin : g_bad_code
    $error("codificador: CODE must be 0, 1 or 2 (got %0d)", CODE);
  end

  if (!(LATENCY inside {[1:4]})) begin : g_bad_latency
    $error("codificador: LATENCY must be 1..4 (got %0d)", LATENCY);
  end

  // Counter is loaded with LATENCY-1 so the result lands exactly LATENCY clocks after accept.
  localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

  function automatic logic [3:0] encode(input logic [3:0] n);
    logic [3:0] r;
    if (CODE == 0)      r = n ^ (n >> 1);
    else if (CODE == 1) r = n + 4'd3;
    else                r = ~n;
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] cnt_q,   cnt_d;
  logic       rdy_q,   rdy_d;
  logic [3:0] word_q,  word_d;
  logic [3:0] s_q,     s_d;
  logic       valid_q, valid_d;
`ifdef CODIFICADOR_PARITY_EN
  logic       parity_q, parity_d;
`endif

  logic accept;
  assign accept = bus.ready & ~rdy_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdy_d    = bus.ready;
    word_d   = word_q;
    s_d      = s_q;
    valid_d  = valid_q;
`ifdef CODIFICADOR_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          word_d  = {bus.A, bus.B, bus.C, bus.D};
          valid_d = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Further ready edges are ignored here; the latched word is finished first.
        if (cnt_q == 2'd0) begin
          s_d      = encode(word_q);
          valid_d  = 1'b1;
`ifdef CODIFICADOR_PARITY_EN
          parity_d = ^encode(word_q);
`endif
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      rdy_q    <= 1'b0;
      word_q   <= 4'd0;
      s_q      <= 4'd0;
      valid_q  <= 1'b0;
`ifdef CODIFICADOR_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      word_q   <= word_d;
      s_q      <= s_d;
      valid_q  <= valid_d;
`ifdef CODIFICADOR_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.S3    = s_q[3];
  assign bus.S2    = s_q[2];
  assign bus.S1    = s_q[1];
  assign bus.S0    = s_q[0];
  assign bus.valid = valid_q;
`ifdef CODIFICADOR_PARITY_EN
  assign bus.P     = parity_q;
`endif

endmodule

// File: tb/tb_codificador.sv
// Self-checking bench for codificador: three instances (Gray/L2, Excess-3/L1, one's complement/L4)
// share one stimulus stream; a timing-level reference model plus a constant vector table judge them.
module tb_codificador;

  logic       clk;
  logic       reset;
  logic       ready_r;
  logic [3:0] word;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  codificador_if if0 ();
  codificador_if if1 ();
  codificador_if if2 ();

  assign {if0.A, if0.B, if0.C, if0.D} = word;
  assign {if1.A, if1.B, if1.C, if1.D} = word;
  assign {if2.A, if2.B, if2.C, if2.D} = word;
  assign if0.ready = ready_r;
  assign if1.ready = ready_r;
  assign if2.ready = ready_r;

  codificador #(.CODE(0), .LATENCY(2)) u0 (.clk(clk), .reset(reset), .bus(if0));
  codificador #(.CODE(1), .LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  codificador #(.CODE(2), .LATENCY(4)) u2 (.clk(clk), .reset(reset), .bus(if2));

  logic [3:0] dut_s [3];
  logic       dut_v [3];
  assign dut_s[0] = {if0.S3, if0.S2, if0.S1, if0.S0};
  assign dut_s[1] = {if1.S3, if1.S2, if1.S1, if1.S0};
  assign dut_s[2] = {if2.S3, if2.S2, if2.S1, if2.S0};
  assign dut_v[0] = if0.valid;
  assign dut_v[1] = if1.valid;
  assign dut_v[2] = if2.valid;
`ifdef CODIFICADOR_PARITY_EN
  logic dut_p [3];
  assign dut_p[0] = if0.P;
  assign dut_p[1] = if1.P;
  assign dut_p[2] = if2.P;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: a conversion accepted in cycle t becomes visible at cycle t+LATENCY.
  bit         m_prev [3];
  bit         m_busy [3];
  int         m_due  [3];
  logic [3:0] m_n    [3];
  logic [3:0] m_s    [3];
  bit         m_v    [3];

  function automatic int code_of(int i);
    return i;
  endfunction

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 4;
  endfunction

  function automatic logic [3:0] ref_code(int code, logic [3:0] n);
    int v;
    v = int'(n);
    if (code == 0)      return 4'(v ^ (v / 2));
    else if (code == 1) return 4'((v + 3) % 16);
    else                return 4'(15 - v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit acc;
    bit was_busy;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        m_prev[i] = 1'b0;
        m_busy[i] = 1'b0;
        m_n[i]    = 4'd0;
        m_s[i]    = 4'd0;
        m_v[i]    = 1'b0;
      end else begin
        acc      = ready_r && !m_prev[i];
        was_busy = m_busy[i];
        if (was_busy && cyc == m_due[i]) begin
          m_s[i]    = ref_code(code_of(i), m_n[i]);
          m_v[i]    = 1'b1;
          m_busy[i] = 1'b0;
        end
        if (acc && !was_busy) begin
          m_n[i]    = word;
          m_busy[i] = 1'b1;
          m_due[i]  = cyc + lat_of(i);
          m_v[i]    = 1'b0;
        end
        m_prev[i] = ready_r;
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_u%0d_s_valid", i), {27'd0, dut_s[i], dut_v[i]}, {27'd0, m_s[i], m_v[i]});
`ifdef CODIFICADOR_PARITY_EN
      check($sformatf("model_u%0d_parity", i), {31'd0, dut_p[i]}, {31'd0, ^m_s[i]});
`endif
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [3:0] n;
    logic [3:0] e0;  // Gray
    logic [3:0] e1;  // Excess-3
    logic [3:0] e2;  // one's complement
  } vec_t;

  vec_t vecs [8];
  int   lat_seen;

  initial begin
    vecs[0] = '{4'b0101, 4'b0111, 4'b1000, 4'b1010};
    vecs[1] = '{4'b1111, 4'b1000, 4'b0010, 4'b0000};
    vecs[2] = '{4'b1010, 4'b1111, 4'b1101, 4'b0101};
    vecs[3] = '{4'b0001, 4'b0001, 4'b0100, 4'b1110};
    vecs[4] = '{4'b1101, 4'b1011, 4'b0000, 4'b0010};
    vecs[5] = '{4'b0110, 4'b0101, 4'b1001, 4'b1001};
    vecs[6] = '{4'b0000, 4'b0000, 4'b0011, 4'b1111};
    vecs[7] = '{4'b1000, 4'b1100, 4'b1011, 4'b0111};

    // Reset held with ready high and an all-ones word.
    reset   = 1'b0;
    ready_r = 1'b1;
    word    = 4'b1111;
    @(negedge clk);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_u%0d_s", i), {28'd0, dut_s[i]}, 32'd0);
      check($sformatf("reset_u%0d_valid", i), {31'd0, dut_v[i]}, 32'd0);
    end

    // Release with ready still high: counts as an accept of 1111.
    reset = 1'b1;
    tick();
    check("post_reset_u0_valid", {31'd0, dut_v[0]}, 32'd0);
    check("post_reset_u0_s", {28'd0, dut_s[0]}, 32'd0);
    for (int k = 0; k < 5; k++) tick();
    check("ready_at_release_u0_s", {28'd0, dut_s[0]}, {28'd0, 4'b1000});
    check("ready_at_release_u0_valid", {31'd0, dut_v[0]}, 32'd1);

    // Level-high ready for 10 clocks, word changed after accept; measure u0 latency.
    ready_r = 1'b0;
    tick();
    word    = 4'b0101;
    ready_r = 1'b1;
    tick();
    check("accept_clears_u0_valid", {31'd0, dut_v[0]}, 32'd0);
    word     = 4'b1010;
    lat_seen = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (lat_seen == 0 && dut_v[0]) lat_seen = k;
    end
    check("u0_latency", lat_seen, 32'd2);
    check("level_ready_u0_s", {28'd0, dut_s[0]}, {28'd0, 4'b0111});
    check("level_ready_u2_s", {28'd0, dut_s[2]}, {28'd0, 4'b1010});

    // Table sweep: word replaced by its complement right after each accept.
    foreach (vecs[v]) begin
      ready_r = 1'b0;
      tick();
      word    = vecs[v].n;
      ready_r = 1'b1;
      tick();
      word    = ~vecs[v].n;
      for (int k = 0; k < 5; k++) tick();
      check($sformatf("table_gray_%b", vecs[v].n), {28'd0, dut_s[0]}, {28'd0, vecs[v].e0});
      check($sformatf("table_xs3_%b", vecs[v].n), {28'd0, dut_s[1]}, {28'd0, vecs[v].e1});
      check($sformatf("table_ones_%b", vecs[v].n), {28'd0, dut_s[2]}, {28'd0, vecs[v].e2});
      check($sformatf("table_valid_%b", vecs[v].n), {29'd0, dut_v[0], dut_v[1], dut_v[2]}, 32'd7);
    end

    // Gray sweep 1..15 with one low clock between requests.
    for (int n = 1; n < 16; n++) begin
      ready_r = 1'b0;
      tick();
      word    = 4'(n);
      ready_r = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) tick();
    end

    // Second ready edge while BUSY: u0 (L2) and u2 (L4) ignore it, u1 (L1) is already done.
    ready_r = 1'b0;
    tick();
    word    = 4'b0001;
    ready_r = 1'b1;
    tick();
    ready_r = 1'b0;
    tick();
    word    = 4'b1111;
    ready_r = 1'b1;
    tick();
    check("busy_edge_u2_valid", {31'd0, dut_v[2]}, 32'd0);
    word = 4'b0000;
    for (int k = 0; k < 4; k++) tick();
    check("busy_edge_u0_s", {28'd0, dut_s[0]}, {28'd0, 4'b0001});
    check("busy_edge_u2_s", {28'd0, dut_s[2]}, {28'd0, 4'b1110});
    check("busy_edge_u1_s", {28'd0, dut_s[1]}, {28'd0, 4'b0010});

    // Reset in the middle of a conversion: nothing may land afterwards.
    ready_r = 1'b0;
    tick();
    word    = 4'b0110;
    ready_r = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("mid_busy_reset_u0", {27'd0, dut_s[0], dut_v[0]}, 32'd0);
    check("mid_busy_reset_u1", {27'd0, dut_s[1], dut_v[1]}, 32'd0);
    reset   = 1'b1;
    ready_r = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("no_late_update_u0", {27'd0, dut_s[0], dut_v[0]}, 32'd0);
    check("no_late_update_u2", {27'd0, dut_s[2], dut_v[2]}, 32'd0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      reset   = ($urandom_range(0, 59) != 0);
      ready_r = ($urandom_range(0, 2) != 0);
      word    = 4'($urandom);
      tick();
    end
    reset   = 1'b1;
    ready_r = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
